// File: rtl/pong_game_logic_if.sv
// Per-frame control inputs and sprite/score outputs exchanged between the Pong
// engine (slave) and the video/input host (master).
interface pong_game_logic_if;
    logic       frame_tick;
    logic       p1_up;
    logic       p1_down;
    logic       p2_up;
    logic       p2_down;
    logic [9:0] square_xpos;
    logic [9:0] square_ypos;
    logic [9:0] paddle1_xpos;
    logic [9:0] paddle1_ypos;
    logic [9:0] paddle2_xpos;
    logic [9:0] paddle2_ypos;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;

    modport master (
        output frame_tick, p1_up, p1_down, p2_up, p2_down,
        input  square_xpos, square_ypos, paddle1_xpos, paddle1_ypos,
               paddle2_xpos, paddle2_ypos, score1, score2, game_over
    );

    modport slave (
        input  frame_tick, p1_up, p1_down, p2_up, p2_down,
        output square_xpos, square_ypos, paddle1_xpos, paddle1_ypos,
               paddle2_xpos, paddle2_ypos, score1, score2, game_over
    );
endinterface

// File: rtl/pong_game_logic.sv
// Frame-rate Pong engine: paddles, ball motion, bounces, scoring and serve/game-over flow.
// Define PONG_AI_PADDLE2_EN to have paddle 2 track the ball instead of following p2 buttons.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_SERVE     | ball parked at centre, serve_cnt counts frames until launch
// S_PLAY      | ball moving, bounces and misses evaluated every frame
// S_GAME_OVER | a score reached WIN_SCORE; everything frozen until rst
module pong_game_logic #(
    parameter int unsigned H_VIDEO       = 640,
    parameter int unsigned V_VIDEO       = 480,
    parameter int unsigned SQUARE_WIDTH  = 16,
    parameter int unsigned PADDLE_WIDTH  = 12,
    parameter int unsigned PADDLE_HEIGHT = 96,
    parameter int unsigned PADDLE1_X     = 32,
    parameter int unsigned PADDLE2_X     = 596,
    parameter int unsigned PADDLE_SPEED  = 4,
    parameter int unsigned BALL_SPEED    = 2,
    parameter int unsigned SERVE_FRAMES  = 60,
    parameter int unsigned WIN_SCORE     = 9
) (
    input  logic              clk_0,
    input  logic              rst,
    pong_game_logic_if.slave  bus
);
    localparam logic [10:0] BALL_X0      = 11'((H_VIDEO - SQUARE_WIDTH) / 2);
    localparam logic [10:0] BALL_Y0      = 11'((V_VIDEO - SQUARE_WIDTH) / 2);
    localparam logic [10:0] PADDLE_Y0    = 11'((V_VIDEO - PADDLE_HEIGHT) / 2);
    localparam logic [10:0] PADDLE_Y_MAX = 11'(V_VIDEO - PADDLE_HEIGHT - 1);
    localparam logic [10:0] BALL_Y_MAX   = 11'(V_VIDEO - 1 - SQUARE_WIDTH);
    localparam logic [10:0] X_LAST       = 11'(H_VIDEO - 1);
    localparam logic [10:0] Y_LAST       = 11'(V_VIDEO - 1);
    localparam logic [10:0] SW           = 11'(SQUARE_WIDTH);
    localparam logic [10:0] PH           = 11'(PADDLE_HEIGHT);
    localparam logic [10:0] P1_FACE      = 11'(PADDLE1_X + PADDLE_WIDTH);
    localparam logic [10:0] P2_FACE      = 11'(PADDLE2_X);
    localparam logic [10:0] PSPD         = 11'(PADDLE_SPEED);
    localparam logic [10:0] BSPD         = 11'(BALL_SPEED);
    localparam int          CNT_W        = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_GAME_OVER} state_t;

    state_t           state;
    logic [9:0]       ball_x, ball_y, paddle1_y, paddle2_y;
    logic             dx_pos, dy_pos;
    logic [3:0]       score1, score2;
    logic             game_over_r;
    logic [CNT_W-1:0] serve_cnt;

    logic [10:0] bx, by, p1e, p2e;
    logic [9:0]  nx, ny, p1_next, p2_next;
    logic        ndx, ndy, ov1, ov2, miss_r, miss_l;
    logic [3:0]  score1_inc, score2_inc;

    function automatic logic [9:0] paddle_move(input logic [9:0] y, input logic up,
                                               input logic dn);
        logic [10:0] ye;
        logic [9:0]  r;
        ye = {1'b0, y};
        r  = y;
        if (up && !dn)
            r = (ye < PSPD) ? 10'd0 : 10'(ye - PSPD);
        else if (dn && !up)
            r = (ye + PSPD > PADDLE_Y_MAX) ? 10'(PADDLE_Y_MAX) : 10'(ye + PSPD);
        return r;
    endfunction

`ifdef PONG_AI_PADDLE2_EN
    logic [10:0] ball_c, pad_c;
    logic        ai_up, ai_dn;
    always_comb begin
        ball_c  = {1'b0, ball_y} + 11'(SQUARE_WIDTH / 2);
        pad_c   = {1'b0, paddle2_y} + 11'(PADDLE_HEIGHT / 2);
        ai_dn   = ball_c >= pad_c + PSPD;
        ai_up   = pad_c >= ball_c + PSPD;
        p2_next = paddle_move(paddle2_y, ai_up, ai_dn);
    end
`else
    always_comb p2_next = paddle_move(paddle2_y, bus.p2_up, bus.p2_down);
`endif

    always_comb begin
        bx         = {1'b0, ball_x};
        by         = {1'b0, ball_y};
        p1e        = {1'b0, paddle1_y};
        p2e        = {1'b0, paddle2_y};
        p1_next    = paddle_move(paddle1_y, bus.p1_up, bus.p1_down);
        score1_inc = score1 + 4'd1;
        score2_inc = score2 + 4'd1;
        // Overlap is tested against the paddle positions from before this frame.
        ov1        = (by <= p1e + PH) && (by + SW >= p1e);
        ov2        = (by <= p2e + PH) && (by + SW >= p2e);

        ny  = ball_y;
        ndy = dy_pos;
        if (!dy_pos && by < BSPD) begin
            ny  = 10'd0;
            ndy = 1'b1;
        end else if (dy_pos && (by + SW + BSPD > Y_LAST)) begin
            ny  = 10'(BALL_Y_MAX);
            ndy = 1'b0;
        end else if (dy_pos) begin
            ny = 10'(by + BSPD);
        end else begin
            ny = 10'(by - BSPD);
        end

        nx     = ball_x;
        ndx    = dx_pos;
        miss_r = 1'b0;
        miss_l = 1'b0;
        if (dx_pos) begin
            if ((bx + SW < P2_FACE) && (bx + SW + BSPD >= P2_FACE) && ov2) begin
                nx  = 10'(P2_FACE - 11'd1 - SW);
                ndx = 1'b0;
            end else if (bx + SW + BSPD > X_LAST) begin
                miss_r = 1'b1;
            end else begin
                nx = 10'(bx + BSPD);
            end
        end else begin
            if ((bx > P1_FACE) && (bx - BSPD <= P1_FACE) && ov1) begin
                nx  = 10'(P1_FACE + 11'd1);
                ndx = 1'b1;
            end else if (bx < BSPD) begin
                miss_l = 1'b1;
            end else begin
                nx = 10'(bx - BSPD);
            end
        end
    end

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            state       <= S_SERVE;
            ball_x      <= 10'(BALL_X0);
            ball_y      <= 10'(BALL_Y0);
            paddle1_y   <= 10'(PADDLE_Y0);
            paddle2_y   <= 10'(PADDLE_Y0);
            dx_pos      <= 1'b1;
            dy_pos      <= 1'b1;
            score1      <= 4'd0;
            score2      <= 4'd0;
            game_over_r <= 1'b0;
            serve_cnt   <= '0;
        end else if (bus.frame_tick) begin
            case (state)
                S_SERVE: begin
                    paddle1_y <= p1_next;
                    paddle2_y <= p2_next;
                    if (serve_cnt == SERVE_LAST) begin
                        state     <= S_PLAY;
                        serve_cnt <= '0;
                    end else begin
                        serve_cnt <= serve_cnt + CNT_W'(1);
                    end
                end
                S_PLAY: begin
                    paddle1_y <= p1_next;
                    paddle2_y <= p2_next;
                    if (miss_r || miss_l) begin
                        ball_x <= 10'(BALL_X0);
                        ball_y <= 10'(BALL_Y0);
                        // Next serve heads toward whoever just conceded.
                        dx_pos <= miss_r;
                        dy_pos <= !dy_pos;
                        if (miss_r) score1 <= score1_inc;
                        else        score2 <= score2_inc;
                        if ((miss_r && score1_inc == 4'(WIN_SCORE)) ||
                            (miss_l && score2_inc == 4'(WIN_SCORE))) begin
                            state       <= S_GAME_OVER;
                            game_over_r <= 1'b1;
                        end else begin
                            state <= S_SERVE;
                        end
                    end else begin
                        ball_x <= nx;
                        ball_y <= ny;
                        dx_pos <= ndx;
                        dy_pos <= ndy;
                    end
                end
                S_GAME_OVER: ;
                default: state <= S_SERVE;
            endcase
        end
    end

    assign bus.square_xpos  = ball_x;
    assign bus.square_ypos  = ball_y;
    assign bus.paddle1_xpos = 10'(PADDLE1_X);
    assign bus.paddle1_ypos = paddle1_y;
    assign bus.paddle2_xpos = 10'(PADDLE2_X);
    assign bus.paddle2_ypos = paddle2_y;
    assign bus.score1       = score1;
    assign bus.score2       = score2;
    assign bus.game_over    = game_over_r;
endmodule

// File: tb/tb_pong_game_logic.sv
// Scoreboard bench for pong_game_logic: directed frame sequences, expectations tagged
// with the frame number at which they must hold, checked by an independent monitor.
module tb_pong_game_logic;
    localparam int SX = 0, SY = 1, P1Y = 2, P2Y = 3, P1X = 4, P2X = 5, S1 = 6, S2 = 7, GO = 8;
    localparam int A = 0, B = 1;

    typedef struct {
        int tick;
        int dut_sel;
        int fld;
        int val;
    } exp_t;

    logic clk_0 = 1'b0;
    logic rst = 1'b0;
    logic frame_tick = 1'b0;
    logic p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;

    exp_t  sb[$];
    int    tick_cnt = 0;
    int    n_pass = 0;
    int    n_total = 0;
    string fld_names[9] = '{"square_xpos", "square_ypos", "paddle1_ypos", "paddle2_ypos",
                            "paddle1_xpos", "paddle2_xpos", "score1", "score2", "game_over"};

    pong_game_logic_if bus_a ();
    pong_game_logic_if bus_b ();

    assign bus_a.frame_tick = frame_tick;
    assign bus_a.p1_up      = p1_up;
    assign bus_a.p1_down    = p1_down;
    assign bus_a.p2_up      = p2_up;
    assign bus_a.p2_down    = p2_down;
    assign bus_b.frame_tick = frame_tick;
    assign bus_b.p1_up      = p1_up;
    assign bus_b.p1_down    = p1_down;
    assign bus_b.p2_up      = p2_up;
    assign bus_b.p2_down    = p2_down;

    pong_game_logic dut_a (.clk_0(clk_0), .rst(rst), .bus(bus_a));
    pong_game_logic #(.WIN_SCORE(1)) dut_b (.clk_0(clk_0), .rst(rst), .bus(bus_b));

    always #20 clk_0 = ~clk_0;

    always @(posedge clk_0) begin
        if (!rst)           tick_cnt <= 0;
        else if (frame_tick) tick_cnt <= tick_cnt + 1;
    end

    function automatic int pick(input int f, input logic [9:0] sx, input logic [9:0] sy,
                                input logic [9:0] p1y, input logic [9:0] p2y,
                                input logic [9:0] p1x, input logic [9:0] p2x,
                                input logic [3:0] s1, input logic [3:0] s2, input logic go);
        case (f)
            SX:      return int'(sx);
            SY:      return int'(sy);
            P1Y:     return int'(p1y);
            P2Y:     return int'(p2y);
            P1X:     return int'(p1x);
            P2X:     return int'(p2x);
            S1:      return int'(s1);
            S2:      return int'(s2);
            default: return int'(go);
        endcase
    endfunction

    function automatic int actual(input int d, input int f);
        if (d == A)
            return pick(f, bus_a.square_xpos, bus_a.square_ypos, bus_a.paddle1_ypos,
                        bus_a.paddle2_ypos, bus_a.paddle1_xpos, bus_a.paddle2_xpos,
                        bus_a.score1, bus_a.score2, bus_a.game_over);
        return pick(f, bus_b.square_xpos, bus_b.square_ypos, bus_b.paddle1_ypos,
                    bus_b.paddle2_ypos, bus_b.paddle1_xpos, bus_b.paddle2_xpos,
                    bus_b.score1, bus_b.score2, bus_b.game_over);
    endfunction

    // Monitor: whenever the frame count reaches an expectation's frame, compare it.
    initial begin
        exp_t  e;
        int    act;
        string nm;
        forever begin
            @(negedge clk_0);
            while (rst && sb.size() > 0 && sb[0].tick <= tick_cnt) begin
                e  = sb.pop_front();
                nm = {(e.dut_sel == A) ? "a." : "b.", fld_names[e.fld]};
                n_total++;
                if (e.tick < tick_cnt) begin
                    $display("FAIL %s: frame %0d passed unchecked (now %0d), required %0d",
                             nm, e.tick, tick_cnt, e.val);
                end else begin
                    act = actual(e.dut_sel, e.fld);
                    if (act == e.val) n_pass++;
                    else $display("FAIL %s @frame %0d: got %0d, required %0d",
                                  nm, e.tick, act, e.val);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic ex(input int t, input int d, input int f, input int v);
        sb.push_back('{tick: t, dut_sel: d, fld: f, val: v});
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_0); #1 frame_tick = 1'b1;
            @(posedge clk_0); #1 frame_tick = 1'b0;
            @(posedge clk_0); #1;
        end
    endtask

    // Reset with a frame pulse inside it, which must be ignored.
    task automatic apply_reset();
        @(posedge clk_0); #1 rst = 1'b0;
        @(posedge clk_0); #1 frame_tick = 1'b1;
        @(posedge clk_0); #1 frame_tick = 1'b0;
        @(posedge clk_0); #1 rst = 1'b1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(posedge clk_0);
            guard++;
        end
        if (sb.size() > 0) begin
            n_total += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    initial begin
        // Phase A: idle play to a right-side miss; dut_b (WIN_SCORE=1) ends there.
        apply_reset();
        ex(0, A, SX, 312);  ex(0, A, SY, 232);  ex(0, A, P1Y, 192); ex(0, A, P2Y, 192);
        ex(0, A, P1X, 32);  ex(0, A, P2X, 596); ex(0, A, S1, 0);    ex(0, A, S2, 0);
        ex(0, A, GO, 0);    ex(0, B, GO, 0);
        ex(60, A, SX, 312); ex(60, A, SY, 232);
        ex(61, A, SX, 314); ex(61, A, SY, 234);
        ex(176, A, SY, 463);
        ex(177, A, SY, 461); ex(177, A, SX, 546);
        ex(194, A, SX, 580); ex(194, A, S1, 0);
        ex(215, A, SX, 622);
        ex(216, A, S1, 1);  ex(216, A, SX, 312); ex(216, A, SY, 232); ex(216, A, GO, 0);
        ex(216, B, S1, 1);  ex(216, B, GO, 1);   ex(216, B, SX, 312);
        ex(226, A, P1Y, 232); ex(226, B, P1Y, 192);
        ex(276, A, SX, 312);
        ex(277, A, SX, 314); ex(277, A, SY, 234);
        ex(277, B, SX, 312); ex(277, B, SY, 232); ex(277, B, GO, 1); ex(277, B, S1, 1);
        run_ticks(216);
        p1_down = 1'b1;
        run_ticks(10);
        p1_down = 1'b0;
        run_ticks(51);
        drain();

        // Phase B: paddle clamps, both-buttons hold, right and left paddle returns.
        apply_reset();
        ex(0, A, P1Y, 192); ex(0, B, GO, 0); ex(0, B, S1, 0); ex(0, B, SX, 312);
        ex(47, A, P1Y, 4);  ex(47, A, P2Y, 380);
        ex(48, A, P1Y, 0);  ex(48, A, P2Y, 383);
        ex(60, A, P1Y, 0);  ex(60, A, P2Y, 383); ex(60, A, SX, 312);
        ex(65, A, P1Y, 20);
        ex(75, A, P1Y, 20);
        ex(193, A, SX, 578);
        ex(194, A, SX, 579); ex(194, A, SY, 427);
        ex(195, A, SX, 577); ex(195, A, S1, 0);
        ex(408, A, SY, 0);
        ex(409, A, SY, 2);
        ex(461, A, SX, 45);
        ex(462, A, SX, 45);
        ex(463, A, SX, 47); ex(463, A, S2, 0); ex(463, A, S1, 0);
        p1_up   = 1'b1;
        p2_down = 1'b1;
        run_ticks(60);
        p1_up   = 1'b0;
        p1_down = 1'b1;
        run_ticks(5);
        p1_up = 1'b1;
        run_ticks(10);
        p1_up   = 1'b0;
        p1_down = 1'b0;
        run_ticks(388);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
